// File: rtl/clock_divider_prog.sv
// Programmable multi-channel clock/tick generator: each channel divides the
// system clock by a runtime divisor with a programmable high time.
module clock_divider_prog #(
   parameter int unsigned WIDTH       = 26,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned DEFAULT_DIV = 50000000,
   localparam int unsigned CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] en,
   input  logic                wr_en,
   input  logic [CHW-1:0]      wr_ch,
   input  logic [WIDTH-1:0]    wr_div,
   input  logic [WIDTH-1:0]    wr_high,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending
);

   localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_DIV / 2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Output level at counter value c: low first, then high for the last H_eff cycles.
   function automatic logic level(input logic [WIDTH-1:0] c,
                                  input logic [WIDTH-1:0] div,
                                  input logic [WIDTH-1:0] high);
      logic [WIDTH-1:0] d_eff;
      logic [WIDTH-1:0] h_eff;
      d_eff = (div == '0) ? WIDTH'(1) : div;
      h_eff = (high > d_eff) ? d_eff : high;
      return c >= (d_eff - h_eff);
   endfunction

   for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
      state_t           state, state_nx;
      logic [WIDTH-1:0] cnt, cnt_nx;
      logic [WIDTH-1:0] act_div, act_div_nx, act_high, act_high_nx;
      logic [WIDTH-1:0] sh_div, sh_div_nx, sh_high, sh_high_nx;
      logic             pend, pend_nx;
      logic             clk_r, clk_nx;
      logic             tick_r, tick_nx;
      logic             wr_hit;
      logic             apply;
      logic [WIDTH-1:0] d_eff;

      // Out-of-range channel numbers never match any generated index.
      assign wr_hit = wr_en && (wr_ch == CHW'(i));
      assign d_eff  = (act_div == '0) ? WIDTH'(1) : act_div;

      always_comb begin
         state_nx    = state;
         cnt_nx      = cnt;
         act_div_nx  = act_div;
         act_high_nx = act_high;
         sh_div_nx   = sh_div;
         sh_high_nx  = sh_high;
         pend_nx     = pend;
         clk_nx      = clk_r;
         tick_nx     = tick_r;
         apply       = 1'b0;

         if (!en[i]) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            clk_nx   = 1'b0;
            tick_nx  = 1'b0;
            apply    = pend;
         end else if (state == ST_IDLE) begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
            clk_nx   = level('0, act_div, act_high);
            tick_nx  = 1'b1;
         end else begin
            cnt_nx = (cnt == d_eff - WIDTH'(1)) ? '0 : cnt + WIDTH'(1);
            apply  = pend && (cnt_nx == '0);
         end

         if (apply) begin
            act_div_nx  = sh_div;
            act_high_nx = sh_high;
            pend_nx     = 1'b0;
         end

         // The level after a wrap uses the freshly applied configuration.
         if (en[i] && state == ST_RUN) begin
            clk_nx  = level(cnt_nx, act_div_nx, act_high_nx);
            tick_nx = (cnt_nx == '0);
         end

         // A same-edge write always waits for the following boundary.
         if (wr_hit) begin
            sh_div_nx  = wr_div;
            sh_high_nx = wr_high;
            pend_nx    = 1'b1;
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            act_div  <= RST_DIV;
            act_high <= RST_HIGH;
            sh_div   <= RST_DIV;
            sh_high  <= RST_HIGH;
            pend     <= 1'b0;
            clk_r    <= 1'b0;
            tick_r   <= 1'b0;
         end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            act_div  <= act_div_nx;
            act_high <= act_high_nx;
            sh_div   <= sh_div_nx;
            sh_high  <= sh_high_nx;
            pend     <= pend_nx;
            clk_r    <= clk_nx;
            tick_r   <= tick_nx;
         end
      end

      assign clk_out[i] = clk_r;
      assign tick[i]    = tick_r;
      assign pending[i] = pend;
   end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Randomized bench for clock_divider_prog against a cycle-level reference model
// built directly from the channel rules.
module tb_clock_divider_prog;

   localparam int unsigned WIDTH       = 8;
   localparam int unsigned CHANNELS    = 3;
   localparam int unsigned DEFAULT_DIV = 5;
   localparam int unsigned CHW         = 2;

   logic                clock;
   logic                reset;
   logic [CHANNELS-1:0] en;
   logic                wr_en;
   logic [CHW-1:0]      wr_ch;
   logic [WIDTH-1:0]    wr_div;
   logic [WIDTH-1:0]    wr_high;
   logic [CHANNELS-1:0] clk_out;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] pending;

   int n_checks;
   int n_fail;

   // Reference model state, one entry per channel
   int m_d[CHANNELS];
   int m_h[CHANNELS];
   int s_d[CHANNELS];
   int s_h[CHANNELS];
   int m_cnt[CHANNELS];
   bit m_pend[CHANNELS];
   bit m_run[CHANNELS];
   bit m_clk[CHANNELS];
   bit m_tick[CHANNELS];

   clock_divider_prog #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEFAULT_DIV(DEFAULT_DIV)
   ) dut (
      .clock(clock), .reset(reset), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_div(wr_div), .wr_high(wr_high), .clk_out(clk_out), .tick(tick),
      .pending(pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit level(input int c, input int d, input int h);
      int de;
      int he;
      de = (d < 1) ? 1 : d;
      he = (h < de) ? h : de;
      return (c >= de - he);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < int'(CHANNELS); c++) begin
         m_d[c] = DEFAULT_DIV;  m_h[c] = DEFAULT_DIV / 2;
         s_d[c] = DEFAULT_DIV;  s_h[c] = DEFAULT_DIV / 2;
         m_cnt[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
   endfunction

   function automatic void model_edge();
      for (int c = 0; c < int'(CHANNELS); c++) begin
         bit old_pend;
         bit applied;
         old_pend = m_pend[c];
         applied  = 0;
         if (!en[c]) begin
            m_run[c] = 0; m_cnt[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            applied = old_pend;
            if (applied) begin m_d[c] = s_d[c]; m_h[c] = s_h[c]; end
         end else if (!m_run[c]) begin
            m_run[c] = 1; m_cnt[c] = 0; m_tick[c] = 1;
            m_clk[c] = level(0, m_d[c], m_h[c]);
         end else begin
            int period;
            period   = (m_d[c] < 1) ? 1 : m_d[c];
            m_cnt[c] = (m_cnt[c] + 1) % period;
            if (m_cnt[c] == 0 && old_pend) begin
               applied = 1; m_d[c] = s_d[c]; m_h[c] = s_h[c];
            end
            m_clk[c]  = level(m_cnt[c], m_d[c], m_h[c]);
            m_tick[c] = (m_cnt[c] == 0);
         end
         if (applied) m_pend[c] = 0;
         if (wr_en && int'(wr_ch) == c) begin
            s_d[c] = int'(wr_div); s_h[c] = int'(wr_high); m_pend[c] = 1;
         end
      end
   endfunction

   task automatic compare_all();
      logic [CHANNELS-1:0] e_clk, e_tick, e_pend;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         e_clk[c] = m_clk[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
      end
      check("clk_out", 32'(clk_out), 32'(e_clk));
      check("tick", 32'(tick), 32'(e_tick));
      check("pending", 32'(pending), 32'(e_pend));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write_step(input int ch, input int d, input int h);
      wr_en = 1'b1; wr_ch = CHW'(ch); wr_div = WIDTH'(d); wr_high = WIDTH'(h);
      step();
      wr_en = 1'b0;
   endtask

   // Asserts reset between edges and checks the outputs drop without a clock edge.
   task automatic async_reset();
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_async_clk", 32'(clk_out), 32'd0);
      check("rst_async_tick", 32'(tick), 32'd0);
      check("rst_async_pend", 32'(pending), 32'd0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
      reset = 1'b1;
      model_reset();
      #2;
      check("rst_clk", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      run(2);

      // Default divisor on channel 0: start edge gives tick with level f(0)=0
      en[0] = 1'b1;
      step();
      check("start_tick", 32'(tick[0]), 32'd1);
      check("start_clk", 32'(clk_out[0]), 32'd0);
      step();
      write_step(0, 4, 1);
      check("wr_pending", 32'(pending[0]), 32'd1);
      run(16);

      // Boundary divisors on channel 1
      en[1] = 1'b1;
      write_step(1, 0, 1);
      run(8);
      write_step(1, 1, 1);
      run(6);
      check("d1_tick", 32'(tick[1]), 32'd1);
      check("d1_clk", 32'(clk_out[1]), 32'd1);
      write_step(1, 6, 0);
      run(14);
      write_step(1, 3, 9);
      run(8);

      // Out-of-range channel select
      en[2] = 1'b1;
      run(3);
      write_step(3, 2, 1);
      check("bad_ch_pend", 32'(pending), 32'd0);
      run(6);

      // Disable, reconfigure while idle, restart
      step();
      en[0] = 1'b0;
      step();
      check("dis_clk", 32'(clk_out[0]), 32'd0);
      write_step(0, 2, 1);
      step();
      check("dis_apply", 32'(pending[0]), 32'd0);
      en[0] = 1'b1;
      run(6);

      // Reset with a write pending mid-period, then defaults resume
      write_step(2, 9, 4);
      async_reset();
      run(12);

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 39) == 0) en[$urandom_range(0, CHANNELS - 1)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            write_step(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 11)));
         end else begin
            step();
         end
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
